// File: rtl/bit_serial_alu_ctrl_if.sv
// Handshake and operand/result bundle between the datapath control FSM
// (master) and the bit-serial ALU sequencer (slave).
interface bit_serial_alu_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [2:0]       op;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             abort;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             zero;
    logic             overflow;
    logic             negative;
    logic             less;

    modport master (
        output start, op, sub, cin, a, b, abort,
        input  ready, busy, done, result, cout, zero, overflow, negative, less
    );

    modport slave (
        input  start, op, sub, cin, a, b, abort,
        output ready, busy, done, result, cout, zero, overflow, negative, less
    );
endinterface

// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial ALU sequencer: runs a WIDTH-bit operation through a single
// 1-bit ALU slice, LSB first, one bit per RUN cycle. Result and flags are
// published only when the last bit has been processed.
module bit_serial_alu_ctrl #(
    parameter int WIDTH = 16
) (
    input logic                 clk,
    input logic                 rst,
    bit_serial_alu_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sh_reg, b_sh_reg, res_sh_reg;
    logic [2:0]       op_reg;
    logic             sub_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] result_reg;
    logic             cout_reg, zero_reg, ovf_reg, neg_reg, less_reg;

    logic             accept;
    logic             last_bit;
    logic             is_arith;
    logic             slice_a, slice_b, slice_res, slice_cout;
    logic [WIDTH-1:0] final_res;
    logic             final_ovf;

    assign accept   = (state_reg != RUN) && bus.start;
    assign last_bit = (state_reg == RUN) && (cnt_reg == CW'(WIDTH - 1));
    assign is_arith = (op_reg == 3'b100);

    // Slice operands: subtraction is done as a + ~b + 1 with the slice's own
    // Sub input held low, since Sub=1 would force the slice carry-in to 1 on
    // every bit instead of only the first.
    assign slice_a = a_sh_reg[0];
    assign slice_b = (is_arith && sub_reg) ? ~b_sh_reg[0] : b_sh_reg[0];

    // One-bit ALU slice.
    always_comb begin
        slice_res  = 1'b0;
        slice_cout = 1'b0;
        case (op_reg)
            3'b000: slice_res = slice_a & slice_b;
            3'b001: slice_res = slice_a | slice_b;
            3'b010: slice_res = slice_a ^ slice_b;
            3'b011: slice_res = ~(slice_a | slice_b);
            3'b100: begin
                slice_res  = slice_a ^ slice_b ^ carry_reg;
                slice_cout = (slice_a & slice_b) | (carry_reg & (slice_a ^ slice_b));
            end
            default: begin
                slice_res  = 1'b0;
                slice_cout = 1'b0;
            end
        endcase
    end

    // Result as it will look after the current bit is shifted in; on the
    // last bit carry_reg is the carry into the MSB, so overflow compares it
    // with the carry out of the MSB.
    assign final_res = {slice_res, res_sh_reg[WIDTH-1:1]};
    assign final_ovf = is_arith & (carry_reg ^ slice_cout);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic; start beats abort because abort only matters in RUN.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = bus.start ? RUN : IDLE;
            RUN: begin
                if (bus.abort)     state_next = IDLE;
                else if (last_bit) state_next = DONE;
                else               state_next = RUN;
            end
            DONE:    state_next = bus.start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        bus.ready = (state_reg == IDLE) || (state_reg == DONE);
        bus.busy  = (state_reg == RUN);
        bus.done  = (state_reg == DONE);
    end

    // Operand capture, per-bit shifting and end-of-operation result publish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            res_sh_reg <= '0;
            op_reg     <= '0;
            sub_reg    <= 1'b0;
            carry_reg  <= 1'b0;
            cnt_reg    <= '0;
            result_reg <= '0;
            cout_reg   <= 1'b0;
            zero_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
            neg_reg    <= 1'b0;
            less_reg   <= 1'b0;
        end else if (accept) begin
            a_sh_reg   <= bus.a;
            b_sh_reg   <= bus.b;
            res_sh_reg <= '0;
            op_reg     <= bus.op;
            sub_reg    <= bus.sub;
            carry_reg  <= (bus.op == 3'b100 && bus.sub) ? 1'b1 : bus.cin;
            cnt_reg    <= '0;
        end else if (state_reg == RUN && !bus.abort) begin
            a_sh_reg   <= a_sh_reg >> 1;
            b_sh_reg   <= b_sh_reg >> 1;
            res_sh_reg <= final_res;
            carry_reg  <= slice_cout;
            cnt_reg    <= cnt_reg + CW'(1);
            if (last_bit) begin
                result_reg <= final_res;
                cout_reg   <= is_arith & slice_cout;
                zero_reg   <= (final_res == '0);
                ovf_reg    <= final_ovf;
                neg_reg    <= final_res[WIDTH-1];
                less_reg   <= is_arith & sub_reg & (final_res[WIDTH-1] ^ final_ovf);
            end
        end
    end

    assign bus.result   = result_reg;
    assign bus.cout     = cout_reg;
    assign bus.zero     = zero_reg;
    assign bus.overflow = ovf_reg;
    assign bus.negative = neg_reg;
    assign bus.less     = less_reg;
endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Randomized and directed bench for bit_serial_alu_ctrl (WIDTH=8), checked
// every cycle against an arithmetic reference model.
module tb_bit_serial_alu_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bit_serial_alu_ctrl_if #(.WIDTH(W)) bus ();
    bit_serial_alu_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int         acc;
        int         dn;
        bit         aborted;
        logic [W-1:0] res;
        logic [4:0] flags;   // {cout, zero, overflow, negative, less}
    } exp_t;

    exp_t q[$];
    exp_t held;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain arithmetic on the whole words.
    function automatic exp_t model(input logic [2:0] op, input logic sub, input logic cin,
                                   input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [W:0]   full;
        logic [W-1:0] r;
        logic c, v, l;
        e = '{default: 0};
        c = 1'b0; v = 1'b0; l = 1'b0;
        full = '0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: r = a ^ b;
            3'd3: r = ~(a | b);
            3'd4: begin
                if (sub) full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
                else     full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                r = full[W-1:0];
                c = full[W];
                if (sub) v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
                else     v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
                l = sub && ($signed(a) < $signed(b));
            end
            default: r = '0;
        endcase
        e.res   = r;
        e.flags = {c, (r == '0), v, r[W-1], l};
        return e;
    endfunction

    // Cycle-by-cycle compare against the expected handshake and held outputs.
    always @(negedge clk) begin
        logic ed, eb;
        if (rst) begin
            chk("rst_ready", bus.ready, 1'b1);
            chk("rst_busy_done", {bus.busy, bus.done}, 2'b00);
            chk("rst_result", bus.result, '0);
            chk("rst_flags", {bus.cout, bus.zero, bus.overflow, bus.negative, bus.less}, 5'b0);
        end else begin
            ed = 1'b0;
            eb = 1'b0;
            if (q.size() > 0) begin
                eb = (cyc >= q[0].acc) && (cyc < q[0].dn);
                if (cyc == q[0].dn) begin
                    ed = !q[0].aborted;
                    if (ed) held = q[0];
                    void'(q.pop_front());
                end
            end
            chk("done", bus.done, ed);
            chk("busy", bus.busy, eb);
            chk("ready", bus.ready, !eb);
            chk("result", bus.result, held.res);
            chk("flags", {bus.cout, bus.zero, bus.overflow, bus.negative, bus.less}, held.flags);
        end
    end

    // Drive a request for one cycle; called at posedge+1.
    task automatic issue(input logic [2:0] op, input logic sub, input logic cin,
                         input logic [W-1:0] a, input logic [W-1:0] b, input bit record);
        exp_t e;
        bus.op = op; bus.sub = sub; bus.cin = cin; bus.a = a; bus.b = b;
        bus.start = 1'b1;
        if (record) begin
            e = model(op, sub, cin, a, b);
            e.acc = cyc + 1;
            e.dn  = cyc + 1 + W;
            q.push_back(e);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!bus.done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.done) chk("done_timeout", 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Directed op: pins the model to a hand-computed value, then runs it.
    task automatic directed(input string name, input logic [2:0] op, input logic sub,
                            input logic cin, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] lit_res, input logic [4:0] lit_flags);
        exp_t m;
        int   n;
        m = model(op, sub, cin, a, b);
        chk({name, "_model_res"}, m.res, lit_res);
        chk({name, "_model_flags"}, m.flags, lit_flags);
        issue(op, sub, cin, a, b, 1'b1);
        wait_done(n);
        chk({name, "_latency"}, n, W);
        chk({name, "_res"}, bus.result, lit_res);
        chk({name, "_flags"}, {bus.cout, bus.zero, bus.overflow, bus.negative, bus.less}, lit_flags);
    endtask

    initial begin
        int n;
        held = '{default: 0};
        bus.start = 1'b0; bus.op = '0; bus.sub = 1'b0; bus.cin = 1'b0;
        bus.a = '0; bus.b = '0; bus.abort = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        // flags = {cout, zero, overflow, negative, less}
        directed("add_7f_01", 3'd4, 1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 5'b00110);
        idle(1);
        directed("sub_05_07", 3'd4, 1'b1, 1'b0, 8'h05, 8'h07, 8'hFE, 5'b00011);
        directed("sub_80_01", 3'd4, 1'b1, 1'b0, 8'h80, 8'h01, 8'h7F, 5'b10101);
        idle(1);
        directed("xor_aa_aa", 3'd2, 1'b0, 1'b0, 8'hAA, 8'hAA, 8'h00, 5'b01000);
        directed("nor_b2b",   3'd3, 1'b0, 1'b0, 8'h0F, 8'hF0, 8'h00, 5'b01000);
        idle(1);
        directed("add_ff_cin", 3'd4, 1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 5'b11000);
        directed("op_101",     3'd5, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'h00, 5'b01000);
        idle(1);

        // start while busy is ignored
        issue(3'd4, 1'b0, 1'b0, 8'h10, 8'h20, 1'b1);
        idle(2);
        issue(3'd1, 1'b0, 1'b0, 8'h55, 8'h0F, 1'b0);
        wait_done(n);
        chk("ignored_start_res", bus.result, 8'h30);
        idle(1);

        // abort in RUN: no done, previous result kept
        issue(3'd4, 1'b0, 1'b0, 8'h11, 8'h22, 1'b1);
        idle(2);
        bus.abort = 1'b1;
        q[0].dn = cyc + 1;
        q[0].aborted = 1'b1;
        idle(1);
        bus.abort = 1'b0;
        idle(W + 2);
        chk("abort_keeps_res", bus.result, 8'h30);

        // abort together with start in IDLE: start wins
        bus.abort = 1'b1;
        issue(3'd4, 1'b0, 1'b0, 8'h03, 8'h04, 1'b1);
        bus.abort = 1'b0;
        wait_done(n);
        chk("abort_start_res", bus.result, 8'h07);
        idle(1);

        // asynchronous reset mid-operation
        issue(3'd4, 1'b0, 1'b0, 8'h33, 8'h44, 1'b1);
        idle(3);
        #3 rst = 1'b1;
        q.delete();
        held = '{default: 0};
        #1;
        chk("async_rst_ready", bus.ready, 1'b1);
        chk("async_rst_busy", bus.busy, 1'b0);
        chk("async_rst_result", bus.result, 8'h00);
        @(posedge clk); #1 rst = 1'b0;
        idle(W + 2);
        directed("add_after_rst", 3'd4, 1'b0, 1'b0, 8'h01, 8'h01, 8'h02, 5'b00000);

        // randomized traffic, including back-to-back starts
        for (int i = 0; i < 300; i++) begin
            issue(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                  W'($urandom), W'($urandom), 1'b1);
            wait_done(n);
            idle($urandom_range(0, 2));
        end
        idle(W + 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
